// File: rtl/rom_if_pkg.sv
// Shared ROM interface constants and the sequencer state type.
package rom_if_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 10;
   localparam int unsigned DEPTH  = 10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      CAPTURE = 3'd2,
      HOLD    = 3'd3,
      FINISH  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/rom_addr_ctr.sv
// Burst address/word counter: modulo-DEPTH address advance and last-word detect.
module rom_addr_ctr
   import rom_if_pkg::*;
#(
   parameter int unsigned ADDR_W = rom_if_pkg::ADDR_W,
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned DEPTH  = rom_if_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic [CNT_W-1:0]  count,
   input  logic              advance,
   output logic [ADDR_W-1:0] cur,
   output logic              last
);

   logic [CNT_W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur       <= '0;
         remaining <= '0;
      end else if (load) begin
         cur       <= base;
         remaining <= count;
      end else if (advance) begin
         // wrap at the last populated location so no unpopulated address is ever presented
         cur       <= (cur == ADDR_W'(DEPTH - 1)) ? '0 : cur + 1'b1;
         remaining <= remaining - 1'b1;
      end
   end

   assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/rom_sequencer.sv
// ROM burst reader: presents each ROM word on a registered valid/ready stream.
module rom_sequencer
   import rom_if_pkg::*;
#(
   parameter int unsigned ADDR_W = rom_if_pkg::ADDR_W,
   parameter int unsigned DATA_W = rom_if_pkg::DATA_W,
   parameter int unsigned DEPTH  = rom_if_pkg::DEPTH,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_cs,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   seq_state_t        state, state_nxt;
   logic              rom_cs_nxt, out_valid_nxt, err_nxt;
   logic [DATA_W-1:0] out_data_nxt;
   logic [ADDR_W-1:0] out_addr_nxt;
   logic              load, advance, last;
   logic [ADDR_W-1:0] cur;

   rom_addr_ctr #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .DEPTH  (DEPTH)
   ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .base    (base_addr),
      .count   (count),
      .advance (advance),
      .cur     (cur),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rom_cs    <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         rom_cs    <= rom_cs_nxt;
         out_data  <= out_data_nxt;
         out_addr  <= out_addr_nxt;
         out_valid <= out_valid_nxt;
         err       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      rom_cs_nxt    = rom_cs;
      out_data_nxt  = out_data;
      out_addr_nxt  = out_addr;
      out_valid_nxt = out_valid;
      err_nxt       = err;
      load          = 1'b0;
      advance       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  state_nxt = FINISH;
               end else if (32'(base_addr) >= DEPTH) begin
                  err_nxt   = 1'b1;
                  state_nxt = FINISH;
               end else begin
                  load       = 1'b1;
                  err_nxt    = 1'b0;
                  rom_cs_nxt = 1'b1;
                  state_nxt  = SETUP;
               end
            end
         end
         SETUP: begin
            if (abort) begin
               rom_cs_nxt = 1'b0;
               state_nxt  = FINISH;
            end else begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            rom_cs_nxt = 1'b0;
            if (abort) begin
               out_valid_nxt = 1'b0;
               state_nxt     = FINISH;
            end else begin
               out_data_nxt  = rom_data;
               out_addr_nxt  = cur;
               out_valid_nxt = 1'b1;
               state_nxt     = HOLD;
            end
         end
         HOLD: begin
            // abort wins over a coincident transfer: the held word is dropped, not counted
            if (abort) begin
               out_valid_nxt = 1'b0;
               state_nxt     = FINISH;
            end else if (out_ready) begin
               out_valid_nxt = 1'b0;
               advance       = 1'b1;
               if (last) begin
                  state_nxt = FINISH;
               end else begin
                  rom_cs_nxt = 1'b1;
                  state_nxt  = SETUP;
               end
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt     = IDLE;
            rom_cs_nxt    = 1'b0;
            out_valid_nxt = 1'b0;
         end
      endcase
   end

   assign rom_addr = cur;
   assign busy     = (state != IDLE);
   assign done     = (state == FINISH);

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer: vector table of bursts plus abort/reset sequences.
module tb_rom_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] base_addr;
   logic [3:0] count;
   logic       abort;
   logic [3:0] rom_addr;
   logic       rom_cs;
   logic [9:0] rom_data;
   logic [9:0] out_data;
   logic [3:0] out_addr;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;
   int cs_total = 0;
   int bad_total = 0;

   always #5 clk = ~clk;

   rom_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .abort     (abort),
      .rom_addr  (rom_addr),
      .rom_cs    (rom_cs),
      .rom_data  (rom_data),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // ROM model: m[i] = 0x100 + i for the populated locations
   assign rom_data = (rom_addr < 4'd10) ? (10'h100 + {6'b0, rom_addr}) : 10'h3FF;

   always @(posedge clk) begin
      if (rom_cs) cs_total <= cs_total + 1;
      if (rom_cs && rom_addr >= 4'd10) bad_total <= bad_total + 1;
   end

   typedef struct {
      logic [3:0] base;
      logic [3:0] cnt;
      int         stall;
      bit         poke;
      int         exp_words;
      int         exp_done;
      int         exp_cs;
      bit         exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int         cyc, words, held, done_cyc, done_cnt, first_v, exp_a, cs0, bad0;
      logic [9:0] hold_d;
      logic [3:0] hold_a;
      cs0 = cs_total; bad0 = bad_total;
      words = 0; held = 0; done_cyc = -1; done_cnt = 0; first_v = -1;
      hold_d = '0; hold_a = '0;
      base_addr = v.base; count = v.cnt; start = 1'b1; out_ready = 1'b0;
      for (cyc = 1; cyc <= v.exp_done + 2; cyc++) begin
         step();
         start = (v.poke && cyc == 2);
         if (v.poke && cyc == 2) begin
            base_addr = 4'd7;
            count     = 4'd9;
         end
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
         end
         if (out_valid) begin
            if (first_v < 0) first_v = cyc;
            if (held == 0) begin
               hold_d = out_data;
               hold_a = out_addr;
            end else begin
               check($sformatf("v%0d stall data", idx), out_data, hold_d);
               check($sformatf("v%0d stall addr", idx), out_addr, hold_a);
            end
            if (held < v.stall) begin
               out_ready = 1'b0;
               held++;
            end else begin
               out_ready = 1'b1;
               held = 0;
               exp_a = (int'(v.base) + words) % 10;
               check($sformatf("v%0d w%0d addr", idx, words), out_addr, exp_a);
               check($sformatf("v%0d w%0d data", idx, words), out_data, 32'h100 + exp_a);
               words++;
            end
         end else begin
            out_ready = 1'b0;
         end
      end
      out_ready = 1'b0;
      start = 1'b0;
      check($sformatf("v%0d words", idx), words, v.exp_words);
      check($sformatf("v%0d done cycle", idx), done_cyc, v.exp_done);
      check($sformatf("v%0d done pulses", idx), done_cnt, 1);
      check($sformatf("v%0d err", idx), err, v.exp_err);
      check($sformatf("v%0d busy after", idx), busy, 0);
      check($sformatf("v%0d cs cycles", idx), cs_total - cs0, v.exp_cs);
      check($sformatf("v%0d bad rom addr", idx), bad_total - bad0, 0);
      if (v.exp_words > 0) check($sformatf("v%0d first valid", idx), first_v, 3);
   endtask

   initial begin
      // base, count, stall, poke, words, done cycle, cs-high cycles, err
      vecs[0] = '{4'd0,  4'd10, 0, 1'b0, 10, 31, 20, 1'b0};
      vecs[1] = '{4'd8,  4'd4,  0, 1'b0, 4,  13, 8,  1'b0};
      vecs[2] = '{4'd2,  4'd3,  5, 1'b0, 3,  25, 6,  1'b0};
      vecs[3] = '{4'd0,  4'd0,  0, 1'b0, 0,  1,  0,  1'b0};
      vecs[4] = '{4'd12, 4'd3,  0, 1'b0, 0,  1,  0,  1'b1};
      vecs[5] = '{4'd5,  4'd1,  0, 1'b0, 1,  4,  2,  1'b0};
      vecs[6] = '{4'd3,  4'd12, 0, 1'b0, 12, 37, 24, 1'b0};
      vecs[7] = '{4'd0,  4'd2,  0, 1'b1, 2,  7,  4,  1'b0};

      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; abort = 1'b0; out_ready = 1'b0;
      step(); step();
      check("reset rom_addr", rom_addr, 0);
      check("reset rom_cs", rom_cs, 0);
      check("reset out_data", out_data, 0);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset err", err, 0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // abort in the second HOLD with out_ready high
      base_addr = 4'd0; count = 4'd5; out_ready = 1'b1; start = 1'b1;
      step(); start = 1'b0;
      step(); step();
      check("abort hold1 valid", out_valid, 1);
      check("abort hold1 data", out_data, 10'h100);
      step(); step(); step();
      check("abort hold2 valid", out_valid, 1);
      check("abort hold2 data", out_data, 10'h101);
      check("abort hold2 addr", out_addr, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort done", done, 1);
      check("abort valid dropped", out_valid, 0);
      check("abort rom_cs", rom_cs, 0);
      step();
      check("abort idle busy", busy, 0);
      check("abort idle done", done, 0);
      base_addr = 4'd6; count = 4'd1; start = 1'b1;
      step(); start = 1'b0;
      check("restart busy", busy, 1);
      check("restart rom_cs", rom_cs, 1);
      check("restart rom_addr", rom_addr, 6);
      step(); step();
      check("restart data", out_data, 10'h106);
      step();
      check("restart done", done, 1);
      step();
      out_ready = 1'b0;

      // reset while holding a word, with start coincident with rst
      base_addr = 4'd4; count = 4'd3; start = 1'b1;
      step(); start = 1'b0;
      step(); step();
      check("pre-rst valid", out_valid, 1);
      check("pre-rst data", out_data, 10'h104);
      rst = 1'b1; start = 1'b1;
      step();
      check("rst rom_addr", rom_addr, 0);
      check("rst rom_cs", rom_cs, 0);
      check("rst out_data", out_data, 0);
      check("rst out_addr", out_addr, 0);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);
      rst = 1'b0; start = 1'b0;
      step();
      check("post-rst busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
